wb_arb2: RTL and testbench
==========================

# wb_arb2

Two-master Wishbone round-robin arbiter that shares one slave port between two requesters (for example a DMA-style peripheral and the LM32 data bus) in front of a single slave such as block RAM. It sits between the masters and one `conbus` slave port, or directly in front of a slave. It owns grant sequencing, routes the handshake back to the granted master only, and can optionally abort stalled cycles with a bus-error watchdog.

## Interface
Parameters:
- `timeout_cycles`, default 255: stall cycles before the watchdog aborts the cycle; legal range 2..255.

Ports (m = 0, 1):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `m<m>_adr_i`  in  32  master address.
- `m<m>_dat_i`  in  32  master write data.
- `m<m>_dat_o`  out  32  read data; `s_dat_i` broadcast to both masters.
- `m<m>_sel_i`  in  4  byte selects.
- `m<m>_we_i`  in  1  write enable.
- `m<m>_cyc_i`  in  1  cycle request.
- `m<m>_stb_i`  in  1  strobe.
- `m<m>_ack_o`  out  1  acknowledge; owner only.
- `m<m>_err_o`  out  1  bus error; owner only, watchdog abort.
- `s_adr_o`  out  32  slave address.
- `s_dat_o`  out  32  slave write data.
- `s_sel_o`  out  4  slave byte selects.
- `s_we_o`  out  1  slave write enable.
- `s_cyc_o`  out  1  slave cycle.
- `s_stb_o`  out  1  slave strobe.
- `s_ack_i`  in  1  slave acknowledge.
- `s_dat_i`  in  32  slave read data.
- `grant_o`  out  2  one-hot owner: bit0 = m0, bit1 = m1.

## Operation
- States: IDLE, OWN0, OWN1, ABORT. ABORT exists only with the watchdog compiled in.
- `last` register: index of the most recently granted master. Reset value 1, so m0 wins the first tie.
- IDLE
  - Only `m0_cyc_i` high: go to OWN0.
  - Only `m1_cyc_i` high: go to OWN1.
  - Both high: grant the master not equal to `last`.
  - On entry to OWNx, set `last` to x.
- OWNx
  - Drive `s_*` combinationally from master x. Drive `s_cyc_o`/`s_stb_o` as `mx_cyc_i`/`mx_stb_i`.
  - `mx_ack_o` = `s_ack_i`. The other master's ack and err stay 0.
  - Ownership holds while `mx_cyc_i` = 1. This covers burst and back-to-back strobes, and the other master cannot preempt.
  - `mx_cyc_i` low: go to IDLE.
- IDLE: all `s_*` outputs are 0 and `grant_o` = 00.
- Watchdog counter (8 bit)
  - Counts cycles in OWNx with `s_stb_o` high and `s_ack_i` low.
  - Clears on `s_ack_i`, on a strobe gap, and on leaving OWNx.
  - Reaching `timeout_cycles`: pulse `mx_err_o` for exactly one cycle and go to ABORT.
- ABORT
  - `s_cyc_o` and `s_stb_o` are forced 0; `grant_o` keeps the owner.
  - A late `s_ack_i` is discarded.
  - Leave to IDLE when the owner's `cyc` is low.
- Reset values: every output 0 (`grant_o` 00, both acks and errs 0, all `s_*` 0), state IDLE, counter 0.

## Timing
- Arbitration latency: a request sampled in IDLE produces the grant and `s_cyc_o` on the next edge. `cyc` to `s_cyc_o` is 1 cycle minimum.
- Release: owner drops `cyc` in cycle N, state is IDLE at N+1, and a pending request is granted at N+2. This gives one idle bus cycle between owners.
- Ack path is purely combinational, `s_ack_i` to `mx_ack_o`, with zero added latency.
- Simultaneous events:
  - `s_ack_i` in the same cycle the watchdog would expire: the ack wins, with no err.
  - Owner drops `cyc` while the other master requests: the other master is granted after the IDLE cycle.
- Reset mid-transfer: asynchronous clear of all outputs, with no ack or err emitted. `last` resets to 1.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - The watchdog counter, ABORT state and `mx_err_o` logic are built.
- `WB_ARB_TIMEOUT_EN` undefined:
  - No counter and no ABORT state.
  - `m0_err_o` and `m1_err_o` are tied 0.
  - A stalled slave holds the bus indefinitely.

## Test plan
- Reset then single request: after release of `rst`, m0 single read at 0x10, slave acks 1 cycle after strobe. Required: `grant_o` = 01 one cycle after `m0_cyc_i`, `m0_ack_o` pulses with data, `m1_ack_o` = 0.
- Tie, round-robin: both masters hold `cyc` continuously, each completing single cycles. Required: grants alternate 01, 10, 01, with one IDLE cycle between owners; m0 is granted first.
- No preemption: m1 raises `cyc` during an m0 4-beat burst. Required: `grant_o` stays 01 until `m0_cyc_i` drops; m1 is granted 2 cycles later.
- Watchdog (macro on, `timeout_cycles` = 8): slave never acks. Required: `m0_err_o` high for one cycle at the 8th stall cycle, then `s_cyc_o` = 0. The state returns to IDLE after m0 drops `cyc`; a late `s_ack_i` is not forwarded.
- Async reset mid-write: assert `rst` low during an OWN1 write. Required: all outputs are 0 immediately, without waiting for `clk`; after release, the next tie is granted to m0.
- Macro off: a stalled slave keeps `s_cyc_o` asserted for 1000 cycles, and `err_o` stays 0.

Source files
------------

// File: rtl/wb_arb2.sv
// Two-master Wishbone round-robin arbiter sharing one slave port.
// Optional bus-error watchdog built when WB_ARB_TIMEOUT_EN is defined.
module wb_arb2 #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o
);

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, ABORT = 2'd3} state_t;
  localparam logic [7:0] TO_LAST = 8'(timeout_cycles - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       stall_s;
  logic       expire_s;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
`endif

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] grant_q, grant_d;
  logic       own_s;
  logic       own_cyc_s;
  logic       own_stb_s;
  logic       pick_s;

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign grant_o   = grant_q;
  // last_q always names the current owner while in OWNx or ABORT.
  assign own_s     = (state_q == OWN0) || (state_q == OWN1);
  assign own_cyc_s = last_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb_s = last_q ? m1_stb_i : m0_stb_i;
  assign pick_s    = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;

`ifdef WB_ARB_TIMEOUT_EN
  // An ack in the expiry cycle is not a stall, so the ack wins over err.
  assign stall_s  = own_s && own_cyc_s && own_stb_s && !s_ack_i;
  assign expire_s = stall_s && (cnt_q == TO_LAST);
`endif

  always_comb begin
    s_adr_o  = 32'd0;
    s_dat_o  = 32'd0;
    s_sel_o  = 4'd0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i;
`ifdef WB_ARB_TIMEOUT_EN
        m0_err_o = expire_s;
`endif
      end
      OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i;
`ifdef WB_ARB_TIMEOUT_EN
        m1_err_o = expire_s;
`endif
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d   = 8'd0;
`endif
    case (state_q)
      IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          state_d = pick_s ? OWN1 : OWN0;
          last_d  = pick_s;
          grant_d = pick_s ? 2'b10 : 2'b01;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (!own_cyc_s) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
          if (expire_s) begin
            state_d = ABORT;
          end else if (stall_s) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = 8'd0;
          end
`else
          state_d = state_q;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        if (!own_cyc_s) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else begin
          state_d = ABORT;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
// Directed self-checking bench for wb_arb2; the watchdog section follows
// WB_ARB_TIMEOUT_EN.
module tb_wb_arb2;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  grant_o;
  int          n_chk = 0;
  int          n_fail = 0;
  int          good;

  wb_arb2 #(.timeout_cycles(8)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    m0_sel_i = 4'hF; m1_sel_i = 4'h3;
    s_ack_i = 1'b0; s_dat_i = 32'd0;
    #3;
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_scyc", 32'(s_cyc_o), 32'd0);
    check("rst_acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // single read by m0
    tick();
    set_m0(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
    #1;
    check("t1_idle_grant", 32'(grant_o), 32'd0);
    check("t1_idle_scyc", 32'(s_cyc_o), 32'd0);
    tick();
    check("t1_grant", 32'(grant_o), 32'h1);
    check("t1_scyc", 32'(s_cyc_o), 32'h1);
    check("t1_sadr", s_adr_o, 32'h10);
    check("t1_sel", 32'(s_sel_o), 32'hF);
    check("t1_noack", 32'(m0_ack_o), 32'd0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0010;
    #1;
    check("t1_ack", 32'(m0_ack_o), 32'h1);
    check("t1_dat", m0_dat_o, 32'hCAFE_0010);
    check("t1_m1ack", 32'(m1_ack_o), 32'd0);
    tick();
    set_m0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    s_ack_i = 1'b0;
    tick();
    check("t1_release", 32'(grant_o), 32'd0);
    rst = 1'b0;
    #1;
    rst = 1'b1;

    // tie: round-robin starting with m0
    tick();
    set_m0(1'b1, 1'b1, 1'b0, 32'h100, 32'd0);
    set_m1(1'b1, 1'b1, 1'b0, 32'h200, 32'd0);
    #1;
    check("rr_idle0", 32'(grant_o), 32'd0);
    tick();
    check("rr_g0", 32'(grant_o), 32'h1);
    check("rr_adr0", s_adr_o, 32'h100);
    s_ack_i = 1'b1;
    #1;
    check("rr_ack0", 32'({m0_ack_o, m1_ack_o}), 32'h2);
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    #1;
    check("rr_hold0", 32'(grant_o), 32'h1);
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    #1;
    check("rr_idle1", 32'(grant_o), 32'd0);
    tick();
    check("rr_g1", 32'(grant_o), 32'h2);
    check("rr_adr1", s_adr_o, 32'h200);
    s_ack_i = 1'b1;
    #1;
    check("rr_ack1", 32'({m0_ack_o, m1_ack_o}), 32'h1);
    tick();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    tick();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    #1;
    check("rr_idle2", 32'(grant_o), 32'd0);
    tick();
    check("rr_g2", 32'(grant_o), 32'h1);

    // m0 4-beat burst, m1 waiting
    for (int i = 0; i < 4; i++) begin
      s_ack_i = 1'b1;
      #1;
      check("np_grant", 32'(grant_o), 32'h1);
      check("np_acks", 32'({m0_ack_o, m1_ack_o}), 32'h2);
      tick();
    end
    set_m0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    s_ack_i = 1'b0;
    #1;
    check("np_drop", 32'(grant_o), 32'h1);
    tick();
    check("np_idle", 32'(grant_o), 32'd0);
    tick();
    check("np_m1", 32'(grant_o), 32'h2);
    set_m1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // watchdog expiry at the 8th stall cycle
    set_m0(1'b1, 1'b1, 1'b0, 32'h40, 32'd0);
    tick();
    for (int k = 1; k < 8; k++) begin
      #1;
      check("wd_noerr", 32'(m0_err_o), 32'd0);
      tick();
    end
    check("wd_err", 32'({m0_err_o, m1_err_o}), 32'h2);
    check("wd_scyc_err", 32'(s_cyc_o), 32'h1);
    tick();
    check("wd_abort_scyc", 32'({s_cyc_o, s_stb_o}), 32'd0);
    check("wd_err_pulse", 32'(m0_err_o), 32'd0);
    check("wd_abort_grant", 32'(grant_o), 32'h1);
    s_ack_i = 1'b1;
    #1;
    check("wd_late_ack", 32'(m0_ack_o), 32'd0);
    tick();
    set_m0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    s_ack_i = 1'b0;
    #1;
    check("wd_abort_hold", 32'(grant_o), 32'h1);
    tick();
    check("wd_idle", 32'(grant_o), 32'd0);
    // ack arriving on the would-be expiry cycle wins
    set_m0(1'b1, 1'b1, 1'b0, 32'h44, 32'd0);
    tick();
    for (int k = 1; k < 8; k++) tick();
    s_ack_i = 1'b1;
    #1;
    check("wd_ackwin_err", 32'(m0_err_o), 32'd0);
    check("wd_ackwin_ack", 32'(m0_ack_o), 32'h1);
    tick();
    set_m0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    s_ack_i = 1'b0;
    tick();
    tick();
`else
    // stalled slave holds the bus with no error
    set_m0(1'b1, 1'b1, 1'b0, 32'h40, 32'd0);
    tick();
    good = 0;
    for (int k = 0; k < 1000; k++) begin
      #1;
      if (s_cyc_o && !m0_err_o && !m1_err_o) good++;
      tick();
    end
    check("noto_hold", 32'(good), 32'd1000);
    set_m0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
`endif

    // async reset during an m1 write
    set_m1(1'b1, 1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF);
    tick();
    check("ar_grant", 32'(grant_o), 32'h2);
    check("ar_wdat", s_dat_o, 32'hDEAD_BEEF);
    check("ar_we", 32'(s_we_o), 32'h1);
    s_ack_i = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check("ar_grant0", 32'(grant_o), 32'd0);
    check("ar_sbus", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'd0);
    check("ar_sadr", s_adr_o | s_dat_o, 32'd0);
    check("ar_acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
    set_m1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    s_ack_i = 1'b0;
    rst = 1'b1;
    tick();
    set_m0(1'b1, 1'b1, 1'b0, 32'h500, 32'd0);
    set_m1(1'b1, 1'b1, 1'b0, 32'h600, 32'd0);
    tick();
    check("ar_tie_m0", 32'(grant_o), 32'h1);
    set_m0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
